// File: rtl/flex_stp_sr_framed.sv
// rtl/flex_stp_sr_framed.sv - framed flexible shift register with bit counter, word capture and valid strobe
module flex_stp_sr_framed #(
    parameter int NUM_BITS   = 8,
    parameter int SHIFT_MSB  = 0,
    parameter int RESET_ONES = 1,
    localparam int CNT_W     = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                load_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic                serial_out,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic [NUM_BITS-1:0] word_out,
    output logic                word_valid,
    output logic [CNT_W-1:0]    bit_count
);

    // Idle value of the shift register; all ones matches the USB idle-J line level.
    localparam logic [NUM_BITS-1:0] SR_IDLE = (RESET_ONES != 0) ? {NUM_BITS{1'b1}} : {NUM_BITS{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(NUM_BITS - 1);

    logic [NUM_BITS-1:0] sr_shifted;
    logic [NUM_BITS-1:0] sr_next;
    logic [NUM_BITS-1:0] word_next;
    logic [CNT_W-1:0]    cnt_next;
    logic                valid_next;

    // Direction of travel: the new bit enters at one end, the outgoing bit leaves the other.
    generate
        if (SHIFT_MSB != 0) begin : g_shift_msb
            assign sr_shifted = {parallel_out[NUM_BITS-2:0], serial_in};
            assign serial_out = parallel_out[NUM_BITS-1];
        end else begin : g_shift_lsb
            assign sr_shifted = {serial_in, parallel_out[NUM_BITS-1:1]};
            assign serial_out = parallel_out[0];
        end
    endgenerate

    // Next-state selection in priority order clear > load > shift > hold.
    always_comb begin
        sr_next    = parallel_out;
        word_next  = word_out;
        cnt_next   = bit_count;
        valid_next = 1'b0;
        if (clear) begin
            sr_next  = SR_IDLE;
            cnt_next = '0;
        end else if (load_enable) begin
            // A shift requested alongside a load is dropped so the loaded word is intact.
            sr_next  = parallel_in;
            cnt_next = '0;
        end else if (shift_enable) begin
            sr_next = sr_shifted;
            if (bit_count == CNT_LAST) begin
                // Last bit of the word: capture the post-shift value and restart the count.
                cnt_next   = '0;
                word_next  = sr_shifted;
                valid_next = 1'b1;
            end else begin
                cnt_next = bit_count + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset; a partial word is simply discarded.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            parallel_out <= SR_IDLE;
            word_out     <= '0;
            word_valid   <= 1'b0;
            bit_count    <= '0;
        end else begin
            parallel_out <= sr_next;
            word_out     <= word_next;
            word_valid   <= valid_next;
            bit_count    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_flex_stp_sr_framed.sv
// tb/tb_flex_stp_sr_framed.sv - self-checking bench for flex_stp_sr_framed
module tb_flex_stp_sr_framed;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clear = 1'b0;
    logic       load_enable = 1'b0;
    logic [7:0] parallel_in = '0;
    logic       shift_enable = 1'b0;
    logic       serial_in = 1'b0;

    logic       a_sout, a_valid;
    logic [7:0] a_pout, a_word;
    logic [2:0] a_cnt;
    logic       b_sout, b_valid;
    logic [3:0] b_pout, b_word;
    logic [1:0] b_cnt;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference state: A is 8-bit LSB-first ones-reset, B is 4-bit MSB-first ones-reset.
    logic [31:0] ma_sr = 32'hFF, ma_wo = 0;
    int          ma_cnt = 0;
    bit          ma_v = 0;
    logic [31:0] mb_sr = 32'hF, mb_wo = 0;
    int          mb_cnt = 0;
    bit          mb_v = 0;

    always #5 clk = ~clk;

    flex_stp_sr_framed #(.NUM_BITS(8), .SHIFT_MSB(0), .RESET_ONES(1)) dut_a (
        .clk(clk), .n_rst(n_rst), .clear(clear), .load_enable(load_enable),
        .parallel_in(parallel_in), .shift_enable(shift_enable), .serial_in(serial_in),
        .serial_out(a_sout), .parallel_out(a_pout), .word_out(a_word),
        .word_valid(a_valid), .bit_count(a_cnt)
    );

    flex_stp_sr_framed #(.NUM_BITS(4), .SHIFT_MSB(1), .RESET_ONES(1)) dut_b (
        .clk(clk), .n_rst(n_rst), .clear(clear), .load_enable(load_enable),
        .parallel_in(parallel_in[3:0]), .shift_enable(shift_enable), .serial_in(serial_in),
        .serial_out(b_sout), .parallel_out(b_pout), .word_out(b_word),
        .word_valid(b_valid), .bit_count(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: the register is a number that gains one bit per shift at the input end.
    task automatic model(input int n, input bit msb, inout logic [31:0] sr, inout int cnt,
                         inout logic [31:0] wo, inout bit v);
        logic [31:0] mask;
        mask = (32'h1 << n) - 1;
        v = 0;
        if (!n_rst) begin
            sr = mask; wo = 0; cnt = 0;
        end else if (clear) begin
            sr = mask; cnt = 0;
        end else if (load_enable) begin
            sr = {24'h0, parallel_in} & mask; cnt = 0;
        end else if (shift_enable) begin
            if (msb) sr = ((sr << 1) | {31'h0, serial_in}) & mask;
            else     sr = (sr >> 1) | ({31'h0, serial_in} << (n - 1));
            cnt++;
            if (cnt == n) begin
                cnt = 0; wo = sr; v = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("a_pout", {24'h0, a_pout}, ma_sr);
        chk("a_word", {24'h0, a_word}, ma_wo);
        chk("a_valid", {31'h0, a_valid}, {31'h0, ma_v});
        chk("a_cnt", {29'h0, a_cnt}, ma_cnt);
        chk("a_sout", {31'h0, a_sout}, {31'h0, ma_sr[0]});
        chk("b_pout", {28'h0, b_pout}, mb_sr);
        chk("b_word", {28'h0, b_word}, mb_wo);
        chk("b_valid", {31'h0, b_valid}, {31'h0, mb_v});
        chk("b_cnt", {30'h0, b_cnt}, mb_cnt);
        chk("b_sout", {31'h0, b_sout}, {31'h0, mb_sr[3]});
    endtask

    // One clock: drive inputs, take the edge, advance both models, then sample 1 time unit later.
    task automatic cyc(input bit r, input bit c, input bit l, input logic [7:0] p,
                       input bit s, input bit si);
        n_rst = r; clear = c; load_enable = l; parallel_in = p; shift_enable = s; serial_in = si;
        @(posedge clk);
        cycle++;
        model(8, 1'b0, ma_sr, ma_cnt, ma_wo, ma_v);
        model(4, 1'b1, mb_sr, mb_cnt, mb_wo, mb_v);
        #1;
        check_all();
    endtask

    task automatic shift_bit(input bit si);
        cyc(1, 0, 0, 8'h00, 1, si);
    endtask

    initial begin
        logic [7:0] seq;
        logic [7:0] sout_seq;
        int         pulse_cycles[$];
        int         max_cnt;
        int         valid_seen;
        logic [7:0] word_before;

        // Reset and idle
        cyc(0, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0);
        chk("rst_pout", {24'h0, a_pout}, 32'hFF);
        chk("rst_word", {24'h0, a_word}, 32'h00);
        chk("rst_valid", {31'h0, a_valid}, 32'h0);
        chk("rst_cnt", {29'h0, a_cnt}, 32'h0);
        chk("rst_sout", {31'h0, a_sout}, 32'h1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'h00, 0, 0);
        chk("idle_pout", {24'h0, a_pout}, 32'hFF);
        chk("idle_cnt", {29'h0, a_cnt}, 32'h0);

        // RX framing: 0xA5 then 0x3C, LSB first, back to back
        seq = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            shift_bit(seq[i]);
            if (a_valid) pulse_cycles.push_back(cycle);
        end
        chk("rx_word_a5", {24'h0, a_word}, 32'hA5);
        chk("rx_valid_a5", {31'h0, a_valid}, 32'h1);
        chk("rx_cnt_wrap", {29'h0, a_cnt}, 32'h0);
        seq = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            shift_bit(seq[i]);
            if (a_valid) pulse_cycles.push_back(cycle);
        end
        chk("rx_word_3c", {24'h0, a_word}, 32'h3C);
        chk("rx_pulse_count", pulse_cycles.size(), 2);
        if (pulse_cycles.size() == 2)
            chk("rx_pulse_spacing", pulse_cycles[1] - pulse_cycles[0], 8);

        // Stalled shifts: shift_enable on alternate cycles
        seq = 8'hA5;
        max_cnt = 0;
        valid_seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 8'h00, 0, 1'b0);
            if (a_valid) valid_seen++;
            shift_bit(seq[i]);
            if (a_cnt > max_cnt) max_cnt = a_cnt;
            if (a_valid && i != 7) valid_seen++;
        end
        chk("stall_valid_last", {31'h0, a_valid}, 32'h1);
        chk("stall_no_early", valid_seen, 0);
        chk("stall_word", {24'h0, a_word}, 32'hA5);
        chk("stall_max_cnt", max_cnt, 7);

        // TX serialise: load with shift also high, then shift out
        cyc(1, 0, 1, 8'h81, 1, 1);
        chk("tx_load_pout", {24'h0, a_pout}, 32'h81);
        chk("tx_load_cnt", {29'h0, a_cnt}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            sout_seq[i] = a_sout;
            shift_bit(1'b1);
        end
        chk("tx_sout_seq", {24'h0, sout_seq}, 32'h81);
        chk("tx_word_ff", {24'h0, a_word}, 32'hFF);
        chk("tx_valid", {31'h0, a_valid}, 32'h1);

        // clear mid-word
        for (int i = 0; i < 3; i++) shift_bit(1'($urandom_range(0, 1)));
        word_before = a_word;
        cyc(1, 1, 0, 8'h00, 1, 0);
        chk("clr_pout", {24'h0, a_pout}, 32'hFF);
        chk("clr_cnt", {29'h0, a_cnt}, 32'h0);
        chk("clr_word_held", {24'h0, a_word}, {24'h0, word_before});
        chk("clr_valid", {31'h0, a_valid}, 32'h0);
        seq = 8'($urandom);
        for (int i = 0; i < 8; i++) shift_bit(seq[i]);
        chk("clr_full_word", {24'h0, a_word}, {24'h0, seq});
        chk("clr_full_valid", {31'h0, a_valid}, 32'h1);

        // Reset mid-word, then the 4-bit MSB-first instance frames 1,1,0,1
        for (int i = 0; i < 5; i++) shift_bit(1'($urandom_range(0, 1)));
        cyc(0, 0, 0, 8'h00, 1, 1);
        chk("mrst_pout", {24'h0, a_pout}, 32'hFF);
        chk("mrst_word", {24'h0, a_word}, 32'h0);
        chk("mrst_cnt", {29'h0, a_cnt}, 32'h0);
        chk("mrst_valid", {31'h0, a_valid}, 32'h0);
        shift_bit(1); shift_bit(1); shift_bit(0); shift_bit(1);
        chk("b_word_d", {28'h0, b_word}, 32'hD);
        chk("b_valid_d", {31'h0, b_valid}, 32'h1);
        chk("a_no_valid", {31'h0, a_valid}, 32'h0);

        // Randomised traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 11) == 0), 8'($urandom),
                ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flex_stp_sr_framed.md
Name: flex_stp_sr_framed

Overview:
- Parametrised successor to the flex shift register used across the USB 1.1 datapath.
- Adds a bit counter, word-complete framing, a captured output word with a one-cycle valid strobe, parallel load and serial out.
- One instance serves as the RX deserialiser (serial bits to bytes, feeding the RX FIFO) or as the TX serialiser (parallel load, then shift out).

Parameters:
NUM_BITS, 8, word width in bits; legal range 2..32.
SHIFT_MSB, 0, 1 = shift toward MSB (serial_in enters bit 0, serial_out is bit NUM_BITS-1); 0 = shift toward LSB (serial_in enters bit NUM_BITS-1, serial_out is bit 0; USB LSB-first).
RESET_ONES, 1, 1 = shift register resets/clears to all ones (idle-J); 0 = all zeros.

Ports:
clk  input  1  system clock; all state updates on rising edge
n_rst  input  1  reset, synchronous, active-low; sampled on rising clk edge
clear  input  1  synchronous framing restart: empties shift register and counter
load_enable  input  1  load parallel_in into shift register
parallel_in  input  NUM_BITS  word to load
shift_enable  input  1  shift one bit this cycle
serial_in  input  1  bit shifted in
serial_out  output  1  current outgoing bit (combinational from shift register)
parallel_out  output  NUM_BITS  live shift register contents
word_out  output  NUM_BITS  last completed word, held until next completion
word_valid  output  1  one-cycle pulse, high in the cycle word_out holds a newly completed word
bit_count  output  max(1,$clog2(NUM_BITS))  shifts taken in the current word, 0..NUM_BITS-1

Behaviour:
- All state is registered on the rising edge of clk.
- Priority at each edge: n_rst low > clear > load_enable > shift_enable > hold.
- Reset (n_rst low at an edge) sets:
  - parallel_out to all ones if RESET_ONES, else all zeros;
  - word_out to 0;
  - word_valid to 0;
  - bit_count to 0.
- Reset mid-word discards the partial word and produces no word_valid.
- clear:
  - parallel_out returns to its reset value; bit_count = 0; word_valid = 0.
  - word_out is held.
- load_enable:
  - parallel_out <= parallel_in; bit_count <= 0; word_valid = 0.
  - A shift in the same cycle is ignored and does not increment the count.
- shift_enable:
  - SHIFT_MSB=1: parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in}.
  - SHIFT_MSB=0: parallel_out <= {serial_in, parallel_out[NUM_BITS-1:1]}.
  - bit_count increments by 1.
- Word completion:
  - Occurs on a shift edge where bit_count == NUM_BITS-1.
  - On that same edge: bit_count wraps to 0; word_out <= the new (post-shift) shift value; word_valid <= 1.
  - word_valid is therefore high in the cycle immediately after the completing edge, coincident with the updated word_out.
- word_valid is 0 in every cycle not following a completion edge. Back-to-back completions (NUM_BITS consecutive shifts, repeated) give isolated pulses spaced NUM_BITS cycles apart.
- Hold (no enables): all registers keep their values; word_valid = 0.
- serial_out is taken from the output-end bit of parallel_out:
  - SHIFT_MSB=1: parallel_out[NUM_BITS-1];
  - SHIFT_MSB=0: parallel_out[0].
  - After a load, it presents the first outgoing bit in the next cycle with zero additional latency.
- Latency:
  - serial_in to parallel_out: 1 cycle.
  - Last bit to word_out/word_valid: 1 cycle.
- No combinational path from inputs to outputs.

Test Plan:
- Reset and idle: n_rst low for 2 edges with RESET_ONES=1, NUM_BITS=8 -> parallel_out=0xFF, word_out=0x00, word_valid=0, bit_count=0, serial_out=1. Hold 5 cycles with no enables -> outputs unchanged.
- RX framing (SHIFT_MSB=0): shift 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> after 8th edge word_out=0xA5, word_valid high exactly 1 cycle, bit_count=0. Continue shifting 0x3C -> second pulse exactly 8 cycles later with word_out=0x3C.
- Stalled shifts: same 0xA5 bit sequence with shift_enable low on alternate cycles -> word_valid only after the 8th actual shift; bit_count never exceeds 7.
- TX serialise (SHIFT_MSB=0): load 0x81 with shift_enable also high -> parallel_out=0x81, bit_count=0. Then 8 shifts with serial_in=1 -> serial_out sequence 1,0,0,0,0,0,0,1. word_valid pulses with word_out=0xFF.
- clear mid-word: 3 bits shifted, then clear -> parallel_out=0xFF, bit_count=0, word_out unchanged, no pulse. The next 8 shifts complete a full word.
- Reset mid-word: 5 bits shifted, then n_rst low one edge -> state at reset values, no word_valid. SHIFT_MSB=1, NUM_BITS=4: shift 1,1,0,1 -> word_out=0xD.
